// File: rtl/jk_ctrl_arbiter_pkg.sv
// Shared definitions for the two-requester JK register-bank arbiter:
// command encodings, FSM state encoding and the default bank width.
package jk_ctrl_arbiter_pkg;

   localparam int N_BITS_DEF = 4;

   typedef enum logic [1:0] {
      CMD_HOLD   = 2'b00,
      CMD_RESET  = 2'b01,
      CMD_SET    = 2'b10,
      CMD_TOGGLE = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_APPLY = 2'b01,
      ST_ACK   = 2'b10
   } state_e;

   function automatic logic cmd_j(input logic [1:0] cmd);
      return (cmd == CMD_SET) || (cmd == CMD_TOGGLE);
   endfunction

   function automatic logic cmd_k(input logic [1:0] cmd);
      return (cmd == CMD_RESET) || (cmd == CMD_TOGGLE);
   endfunction

endpackage

// File: rtl/jk_ctrl_arbiter_jkff_bank.sv
// Bank of N_BITS JK flip-flops sharing one clock and asynchronous
// active-low reset; each bit has its own J/K inputs.
module jkff_bank
   import jk_ctrl_arbiter_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [N_BITS-1:0] j_i,
   input  logic [N_BITS-1:0] k_i,
   output logic [N_BITS-1:0] q_o
);

   logic [N_BITS-1:0] q_q;
   logic [N_BITS-1:0] q_d;

   // JK characteristic equation, bitwise: Q+ = J&~Q | ~K&Q
   assign q_d = (j_i & ~q_q) | (~k_i & q_q);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/jk_ctrl_arbiter.sv
// Round-robin arbiter granting two requesters single-shot JK commands
// on a shared register bank, with a four-phase REQ/GNT handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; samples REQ0/REQ1, latches winner's CMD/MASK
// ST_APPLY | drives J/K into the bank for exactly one cycle
// ST_ACK   | GNT of winner high until the winner's REQ is seen low
module jk_ctrl_arbiter
   import jk_ctrl_arbiter_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ0,
   input  logic [1:0]        CMD0,
   input  logic [N_BITS-1:0] MASK0,
   input  logic              REQ1,
   input  logic [1:0]        CMD1,
   input  logic [N_BITS-1:0] MASK1,
   output logic              GNT0,
   output logic              GNT1,
   output logic              BUSY,
   output logic [N_BITS-1:0] Q
);

   state_e            state_q;
   logic              ptr_q;
   logic              win_q;
   logic [1:0]        cmd_q;
   logic [N_BITS-1:0] mask_q;
   logic              gnt0_q;
   logic              gnt1_q;

   logic              win_d;
   logic [1:0]        cmd_d;
   logic [N_BITS-1:0] mask_d;
   logic              win_req;
   logic [N_BITS-1:0] bank_j;
   logic [N_BITS-1:0] bank_k;

   always_comb begin
      win_d = 1'b0;
      if (REQ0 && REQ1) begin
         win_d = ptr_q;
      end else if (REQ1) begin
         win_d = 1'b1;
      end
      cmd_d   = win_d ? CMD1  : CMD0;
      mask_d  = win_d ? MASK1 : MASK0;
      win_req = win_q ? REQ1  : REQ0;
   end

   // Bank sees a non-zero J/K only in APPLY, so a held REQ cannot re-apply.
   always_comb begin
      bank_j = '0;
      bank_k = '0;
      if (state_q == ST_APPLY) begin
         bank_j = mask_q & {N_BITS{cmd_j(cmd_q)}};
         bank_k = mask_q & {N_BITS{cmd_k(cmd_q)}};
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         cmd_q   <= '0;
         mask_q  <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (REQ0 || REQ1) begin
                  win_q   <= win_d;
                  cmd_q   <= cmd_d;
                  mask_q  <= mask_d;
                  ptr_q   <= ~win_d;
                  state_q <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               gnt0_q  <= ~win_q;
               gnt1_q  <= win_q;
               state_q <= ST_ACK;
            end
            ST_ACK: begin
               if (!win_req) begin
                  gnt0_q  <= 1'b0;
                  gnt1_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   jkff_bank #(
      .N_BITS (N_BITS)
   ) u_bank (
      .CLK   (CLK),
      .RST_N (RST_N),
      .j_i   (bank_j),
      .k_i   (bank_k),
      .q_o   (Q)
   );

   assign GNT0 = gnt0_q;
   assign GNT1 = gnt1_q;
   assign BUSY = (state_q != ST_IDLE);

endmodule
